// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor: DATA_W-bit a - b through one SLICE_W-bit slice per cycle, LSB first.
// Optional macro NIBBLE_SUB_OVERFLOW_EN adds a registered signed-overflow flag (otherwise overflow is tied to 0).
module nibble_serial_subtractor #(
    parameter  int SLICE_W    = 4,
    parameter  int NUM_SLICES = 4,
    localparam int DATA_W     = SLICE_W * NUM_SLICES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              borrow,
    output logic              zero,
    output logic              overflow
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  idx_reg;
    logic              borrow_flop_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [DATA_W-1:0] work_reg, work_next;
    logic [DATA_W-1:0] diff_reg;
    logic              borrow_reg;
    logic              zero_reg;

    logic [SLICE_W-1:0] a_slices [NUM_SLICES];
    logic [SLICE_W-1:0] b_slices [NUM_SLICES];
    logic [SLICE_W:0]   slice_full;
    logic               last_slice;
    logic               finish_op;

    // Split the latched operands into slices; the working diff only takes the active slice.
    generate
        for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
            assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign work_next[gi*SLICE_W +: SLICE_W] =
                (idx_reg == IDX_W'(gi)) ? slice_full[SLICE_W-1:0]
                                        : work_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    // Extra top bit of the SLICE_W+1 result is the borrow out of this slice.
    always_comb begin
        slice_full = {1'b0, a_slices[idx_reg]}
                   - {1'b0, b_slices[idx_reg]}
                   - (SLICE_W+1)'(borrow_flop_reg);
    end

    assign last_slice = (idx_reg == IDX_W'(NUM_SLICES - 1));
    assign finish_op  = (state_reg == RUN) && last_slice;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg         <= '0;
            borrow_flop_reg <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            work_reg        <= '0;
            diff_reg        <= '0;
            borrow_reg      <= 1'b0;
            zero_reg        <= 1'b0;
        end else begin
            if (state_reg == IDLE && in_valid) begin
                a_reg           <= a;
                b_reg           <= b;
                idx_reg         <= '0;
                borrow_flop_reg <= 1'b0;
                work_reg        <= '0;
            end
            if (state_reg == RUN) begin
                work_reg        <= work_next;
                borrow_flop_reg <= slice_full[SLICE_W];
                if (!last_slice) begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end
            // Visible results move only on DONE entry, never slice by slice.
            if (finish_op) begin
                diff_reg   <= work_next;
                borrow_reg <= slice_full[SLICE_W];
                zero_reg   <= (work_next == '0);
            end
        end
    end

`ifdef NIBBLE_SUB_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (finish_op) begin
            overflow_reg <= (a_reg[MSB] != b_reg[MSB]) && (work_next[MSB] != a_reg[MSB]);
        end
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;
    assign zero      = zero_reg;

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor: computes DATA_W-bit A − B over NUM_SLICES cycles through one SLICE_W-bit datapath.
- Borrow ripples LSB slice to MSB slice through a registered borrow flop.
- Companion to the team's registered nibble adder; serves arithmetic paths that need difference and borrow.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- SLICE_W, 4: width of the per-cycle subtract datapath in bits.
- NUM_SLICES, 4: slices per operation.
- DATA_W = SLICE_W*NUM_SLICES (16 by default): operand and result width. Derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block can accept operands.
- a  input  DATA_W  minuend, unsigned.
- b  input  DATA_W  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  DATA_W  (a − b) mod 2^DATA_W.
- borrow  output  1  1 when a < b (unsigned).
- zero  output  1  1 when diff == 0.
- overflow  output  1  signed overflow flag; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state to IDLE, slice index to 0, borrow flop to 0;
  - operand registers and diff register to 0;
  - in_ready=1, out_valid=0, borrow=0, zero=0, overflow=0.
- in_ready = (state == IDLE), registered and decoded from state.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready, latch a, b; clear the borrow flop and the slice index.
  - Go to RUN.
- RUN, one slice per cycle, index i = 0..NUM_SLICES−1, LSB first:
  - {bout, d} = a_slice[i] − b_slice[i] − bin, computed at SLICE_W+1 bits.
  - d is written to diff slice i; bout goes into the borrow flop for slice i+1.
  - Slice 0 uses bin=0.
  - After slice NUM_SLICES−1, go to DONE. borrow = final bout, zero = (full diff == 0).
- DONE:
  - out_valid=1; diff, borrow, zero and overflow are held stable.
  - On out_ready, go to IDLE the next edge; out_valid drops.
- Latency:
  - Accept on edge k gives out_valid high after edge k+NUM_SLICES (4 cycles by default).
  - Minimum issue interval is NUM_SLICES+2 cycles with out_ready held high.
- in_valid while not IDLE is ignored. Operands are not sampled and no error is raised.
- out_ready while not DONE has no effect.
- Outputs diff, borrow and zero change only on the DONE entry edge. They are not updated slice-by-slice on the output ports: use an internal working register and copy it into the output registers on DONE entry.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No out_valid follows for the aborted operation.
- a == b gives diff=0, borrow=0, zero=1.
- a=0, b=2^DATA_W−1 gives diff=1, borrow=1.

Optional Feature:
- Macro: NIBBLE_SUB_OVERFLOW_EN.
- Defined:
  - overflow = signed overflow of the DATA_W-bit two's-complement subtraction.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Registered on DONE entry, reset to 0, held through DONE.
- Not defined: overflow tied to 0; no overflow logic is synthesised.

Test Plan:
- Basic: reset, then a=0x1234, b=0x0034 with in_valid one cycle → out_valid after 4 cycles; diff=0x1200, borrow=0, zero=0; in_ready=0 during RUN.
- Borrow chain: a=0x0000, b=0x0001 → diff=0xFFFF, borrow=1, zero=0. Every slice must propagate the borrow.
- Zero and stall: a=0xABCD, b=0xABCD, out_ready low for 3 cycles → out_valid, diff=0x0000, zero=1 held stable all 3 cycles. Then out_ready=1 → IDLE, in_ready=1 next cycle.
- Overflow (macro defined): a=0x8000, b=0x0001 → diff=0x7FFF, borrow=0, overflow=1. Macro undefined → overflow=0.
- Reset mid-operation: accept a=0x00FF, b=0x0F00, assert reset at cycle 2 of RUN → all outputs at reset values immediately, in_ready=1, no out_valid. Then a=0x0005, b=0x0003 → diff=0x0002.
- Back-to-back: hold in_valid high with 3 operand pairs, out_ready=1 → each accepted only in IDLE; results in order with the stated latency; ignored in_valid during RUN causes no corruption.
